gray_sync_decode: RTL and testbench

//  Receives a Gray-coded pointer/count from an upstream Gray encoder, usually in another clock domain.

---
 rtl/gray_sync_decode.sv | 111 +++++++++++
 tb/tb_gray_sync_decode.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sync_decode.sv
// gray_sync_decode: brings a Gray-coded pointer/count into the clk domain
// through a plain flop chain. It decodes the synchronised value to binary and
// pulses changed/up on every new value.
// Optional: define GRAY_STEP_CHECK_EN to flag Gray steps that flip more than
// one bit (step_err) and to count them (err_cnt, saturating at 255).
// Reset rst is synchronous, active-low, and takes priority over everything.
module gray_sync_decode #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             changed,
  output logic             up,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  // Synchroniser chain. Element 0 samples the asynchronous input.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  // Last registered gray_sync. Only the Gray domain is compared for "changed".
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_bin;
  logic                              r_changed;
  logic                              r_up;

  logic [WIDTH-1:0]                  w_dec;
  logic [WIDTH-1:0]                  w_bin_inc;
  logic                              w_changed;
  logic                              w_up;

  assign gray_sync = r_sync[SYNC_STAGES-1];
  assign bin_out   = r_bin;
  assign changed   = r_changed;
  assign up        = r_up;

  // Each binary bit is the XOR of all Gray bits at or above it.
  // Each bit is written as its own reduction, so there is no bit-to-bit chain.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign w_dec[gi] = ^gray_sync[WIDTH-1:gi];
    end
  endgenerate

  // The increment wraps naturally at 2^WIDTH, so 7 -> 0 counts as an up step.
  assign w_bin_inc = r_bin + WIDTH'(1);
  assign w_changed = (gray_sync != r_prev);
  assign w_up      = w_changed && (w_dec == w_bin_inc);

  // Flop chain only. There is no logic between stages, so metastability settles undisturbed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Register the decode and the change/direction pulses on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev    <= '0;
      r_bin     <= '0;
      r_changed <= 1'b0;
      r_up      <= 1'b0;
    end else begin
      r_prev    <= gray_sync;
      r_bin     <= w_dec;
      r_changed <= w_changed;
      r_up      <= w_up;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] w_diff;
  logic             w_multi;
  logic             r_step_err;
  logic [7:0]       r_err_cnt;

  // More than one set bit means clearing the lowest set bit leaves something behind.
  assign w_diff  = gray_sync ^ r_prev;
  assign w_multi = ((w_diff & (w_diff - WIDTH'(1))) != '0);

  assign step_err = r_step_err;
  assign err_cnt  = r_err_cnt;

  // Flag illegal multi-bit Gray steps and keep a saturating tally that only reset clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_step_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_step_err <= w_multi;
      if (w_multi && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end
`else
  assign step_err = 1'b0;
  assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_gray_sync_decode.sv
// Testbench for gray_sync_decode. It applies directed scenarios followed by
// randomised Gray traffic. A history-based reference model pushes the expected
// outputs for every clock edge into a queue. A separate monitor pops each entry
// and compares it with the DUT.
`timescale 1ns/1ps
module tb_gray_sync_decode;
  localparam int W  = 3;
  localparam int S  = 2;
  localparam int HN = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] gray_sync;
  logic [W-1:0] bin_out;
  logic         changed;
  logic         up;
  logic         step_err;
  logic [7:0]   err_cnt;

  gray_sync_decode #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .gray_sync(gray_sync),
    .bin_out  (bin_out),
    .changed  (changed),
    .up       (up),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    int           idx;
    logic [W-1:0] gs;
    logic [W-1:0] bo;
    logic         ch;
    logic         up;
    logic         se;
    logic [7:0]   ec;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] gin_h[HN];
  logic         rst_h[HN];
  int           edge_n = 0;
  int           model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Binary value of a Gray word: XOR of the word with all of its right shifts.
  function automatic int bin_of(input logic [W-1:0] g);
    int b = 0;
    for (int i = 0; i < W; i++) b = b ^ (int'(g) >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] gray_of(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int ones(input logic [W-1:0] x);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(x[i]);
    return c;
  endfunction

  // gray_sync seen after edge m. It is the input sampled S-1 edges earlier,
  // unless a reset edge occurred in between and wiped it.
  function automatic logic [W-1:0] g_after(input int m);
    int src;
    if (m < 0) return '0;
    src = m - S + 1;
    if (src < 0) return '0;
    for (int k = src; k <= m; k++) if (!rst_h[k]) return '0;
    return gin_h[src];
  endfunction

  // Last registered gray_sync after edge m.
  function automatic logic [W-1:0] p_after(input int m);
    if (m < 0) return '0;
    if (!rst_h[m]) return '0;
    return g_after(m - 1);
  endfunction

  // Reference model: record the inputs at each edge and push the outputs expected after that edge.
  initial begin
    exp_t         e;
    logic [W-1:0] g;
    logic [W-1:0] p;
    bit           stp;
    forever begin
      @(posedge clk);
      if (edge_n < HN) begin
        gin_h[edge_n] = gray_in;
        rst_h[edge_n] = rst;
        e     = '0;
        e.idx = edge_n;
        e.gs  = g_after(edge_n);
        if (!rst_h[edge_n]) begin
          model_cnt = 0;
        end else begin
          g    = g_after(edge_n - 1);
          p    = p_after(edge_n - 1);
          e.bo = W'(bin_of(g));
          e.ch = (g != p);
          e.up = e.ch && (bin_of(g) == ((bin_of(p) + 1) % (1 << W)));
          stp  = (ones(g ^ p) > 1);
          if (CHK_EN) begin
            e.se = stp;
            if (stp && model_cnt < 255) model_cnt++;
            e.ec = 8'(model_cnt);
          end
        end
        q.push_back(e);
        edge_n++;
      end
    end
  end

  // Monitor: 1 ns after each edge, pop the expected entry and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("gray_sync@%0d", e.idx), 32'(gray_sync), 32'(e.gs));
        chk($sformatf("bin_out@%0d",   e.idx), 32'(bin_out),   32'(e.bo));
        chk($sformatf("changed@%0d",   e.idx), 32'(changed),   32'(e.ch));
        chk($sformatf("up@%0d",        e.idx), 32'(up),        32'(e.up));
        chk($sformatf("step_err@%0d",  e.idx), 32'(step_err),  32'(e.se));
        chk($sformatf("err_cnt@%0d",   e.idx), 32'(err_cnt),   32'(e.ec));
        if (e.ch)
          $display("[TB] edge %0d: bin_out=%0d up=%0d step_err=%0d err_cnt=%0d",
                   e.idx, bin_out, up, step_err, err_cnt);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then random Gray traffic with occasional resets.
  initial begin
    logic [W-1:0] seq [8];
    int           cur;
    int           r;
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // Reset held with a nonzero input, then release.
    rst = 1'b0; gray_in = 3'b101;
    tick(3);
    chk("t1_rst_bin", 32'(bin_out), 32'd0);
    chk("t1_rst_changed", 32'(changed), 32'd0);
    rst = 1'b1;
    tick(3);
    chk("t1_bin", 32'(bin_out), 32'd6);
    chk("t1_changed", 32'(changed), 32'd1);
    tick(1);

    // Full Gray walk, one step every 4 clks.
    for (int i = 0; i < 8; i++) begin
      gray_in = seq[i];
      tick(3);
      chk($sformatf("t2_bin_%0d", i), 32'(bin_out), 32'(i));
      chk($sformatf("t2_changed_%0d", i), 32'(changed), 32'd1);
      chk($sformatf("t2_up_%0d", i), 32'(up), (i > 0) ? 32'd1 : 32'd0);
      tick(1);
    end

    // Wrap-around in both directions.
    gray_in = 3'b000; tick(3);
    chk("t3_wrap_bin", 32'(bin_out), 32'd0);
    chk("t3_wrap_up", 32'(up), 32'd1);
    tick(1);
    gray_in = 3'b100; tick(3);
    chk("t3_back_bin", 32'(bin_out), 32'd7);
    chk("t3_back_changed", 32'(changed), 32'd1);
    chk("t3_back_up", 32'(up), 32'd0);
    tick(1);

    // Illegal two-bit jump after a clean reset.
    rst = 1'b0; gray_in = 3'b000; tick(1);
    rst = 1'b1; tick(4);
    gray_in = 3'b011; tick(3);
    chk("t4_bin", 32'(bin_out), 32'd2);
    chk("t4_up", 32'(up), 32'd0);
    chk("t4_step_err", 32'(step_err), CHK_EN ? 32'd1 : 32'd0);
    chk("t4_err_cnt", 32'(err_cnt), CHK_EN ? 32'd1 : 32'd0);
    tick(1);

    // Reset in mid-operation at bin_out=5.
    gray_in = 3'b111; tick(4);
    chk("t5_pre_bin", 32'(bin_out), 32'd5);
    rst = 1'b0; tick(1);
    chk("t5_rst_bin", 32'(bin_out), 32'd0);
    chk("t5_rst_changed", 32'(changed), 32'd0);
    chk("t5_rst_gray_sync", 32'(gray_sync), 32'd0);
    rst = 1'b1; tick(3);
    chk("t5_bin", 32'(bin_out), 32'd5);
    chk("t5_changed", 32'(changed), 32'd1);
    chk("t5_up", 32'(up), 32'd0);
    tick(1);

    // err_cnt saturation with 300 alternating illegal jumps.
    rst = 1'b0; gray_in = 3'b000; tick(1);
    rst = 1'b1; tick(4);
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 3'b011 : 3'b000;
      tick(4);
    end
    chk("t6_err_cnt_sat", 32'(err_cnt), CHK_EN ? 32'd255 : 32'd0);
    gray_in = 3'b011; tick(8);
    chk("t6_err_cnt_hold", 32'(err_cnt), CHK_EN ? 32'd255 : 32'd0);
    rst = 1'b0; tick(1);
    chk("t6_err_cnt_rst", 32'(err_cnt), 32'd0);
    rst = 1'b1; gray_in = 3'b000; tick(4);

    // Random traffic: mostly +/-1 Gray steps, some arbitrary jumps, rare resets.
    cur = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst = 1'b0;
      end else begin
        rst = 1'b1;
        if (r < 50)      cur = (cur + 1) % (1 << W);
        else if (r < 75) cur = (cur + (1 << W) - 1) % (1 << W);
        else if (r < 90) cur = int'($urandom_range(0, (1 << W) - 1));
        gray_in = gray_of(cur);
      end
      tick(int'($urandom_range(1, 3)));
    end
    rst = 1'b1;
    tick(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
